// File: rtl/match_regfile_pkg.sv
// Shared constants and helpers for the match register file.
package match_regfile_pkg;

    // Per-entry hit counter width and its saturation ceiling.
    localparam int          HIT_W   = 8;
    localparam logic [7:0]  HIT_SAT = 8'd255;

    // Ceiling log2, used to size address ports from DEPTH.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Increment that sticks at the counter ceiling instead of wrapping.
    function automatic logic [HIT_W-1:0] hit_sat_inc(input logic [HIT_W-1:0] v);
        return (v == HIT_SAT) ? HIT_SAT : v + HIT_W'(1);
    endfunction

endpackage

// File: rtl/match_regfile_match_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot grant plus a found flag.
module match_prio_enc
    import match_regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] i_req,
    output logic [DEPTH-1:0] o_gnt,
    output logic             o_found
);

    // Walk upward from entry 0; the first request seen takes the grant.
    always_comb begin
        o_gnt   = '0;
        o_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_req[i] && !o_found) begin
                o_gnt[i] = 1'b1;
                o_found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/match_regfile.sv
// Key-matched register file: each entry holds a pattern/mask, a data word,
// a saturating hit counter and a sticky status flag. A key event updates
// only the lowest-index matching entry; hosts can write and read entries.
module match_regfile
    import match_regfile_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter int               DEPTH = 4,
    parameter int               KEYW  = 3,
    parameter logic [WIDTH-1:0] FILL  = {WIDTH{1'b1}},
    localparam int              AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [KEYW-1:0]  in_key,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [KEYW-1:0]  cfg_pat,
    input  logic [KEYW-1:0]  cfg_mask,
    input  logic             cfg_en,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic [DEPTH-1:0] status_clr,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic [HIT_W-1:0] rd_hits,
    output logic [DEPTH-1:0] status,
    output logic             any_status
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [KEYW-1:0]  r_pat  [DEPTH];
    logic [KEYW-1:0]  r_mask [DEPTH];
    logic [DEPTH-1:0] r_en;
    logic [HIT_W-1:0] r_hits [DEPTH];
    logic [DEPTH-1:0] r_status;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;
    logic [HIT_W-1:0] r_rd_hits;

    logic [DEPTH-1:0] w_req;
    logic [DEPTH-1:0] w_gnt;
    logic             w_found;
    logic             w_cfg_ok;
    logic             w_wr_ok;
    logic             w_rd_ok;

    // Addresses beyond the populated entries are treated as no-ops.
    assign w_cfg_ok = ({1'b0, cfg_addr} < DEPTH_V);
    assign w_wr_ok  = ({1'b0, wr_addr}  < DEPTH_V);
    assign w_rd_ok  = ({1'b0, rd_addr}  < DEPTH_V);

    // Compare the key against every enabled entry using the current config.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_req[i] = in_valid && r_en[i] &&
                       ((in_key & r_mask[i]) == (r_pat[i] & r_mask[i]));
        end
    end

    match_prio_enc #(
        .DEPTH (DEPTH)
    ) u_prio (
        .i_req   (w_req),
        .o_gnt   (w_gnt),
        .o_found (w_found)
    );

    // Entry storage: config, data (host write beats match fill), status, hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_pat[i]  <= '0;
                r_mask[i] <= '0;
                r_hits[i] <= '0;
            end
            r_en     <= '0;
            r_status <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cfg_we && w_cfg_ok && (cfg_addr == AW'(i))) begin
                    r_pat[i]  <= cfg_pat;
                    r_mask[i] <= cfg_mask;
                    r_en[i]   <= cfg_en;
                end
                if (wr_en && w_wr_ok && (wr_addr == AW'(i))) begin
                    r_data[i] <= wr_data;
                end else if (w_found && w_gnt[i]) begin
                    r_data[i] <= FILL;
                end
                if (w_found && w_gnt[i]) begin
                    r_status[i] <= 1'b1;
                end else if (status_clr[i]) begin
                    r_status[i] <= 1'b0;
                end
                // A read clears the counter; a simultaneous match leaves it at 1.
                if (w_found && w_gnt[i]) begin
                    if (rd_en && w_rd_ok && (rd_addr == AW'(i))) begin
                        r_hits[i] <= HIT_W'(1);
                    end else begin
                        r_hits[i] <= hit_sat_inc(r_hits[i]);
                    end
                end else if (rd_en && w_rd_ok && (rd_addr == AW'(i))) begin
                    r_hits[i] <= '0;
                end
            end
        end
    end

    // Read response one cycle after the request, sampling pre-update contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_hits  <= '0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_ok ? r_data[rd_addr] : '0;
                r_rd_hits <= w_rd_ok ? r_hits[rd_addr] : '0;
            end
        end
    end

    assign rd_valid   = r_rd_valid;
    assign rd_data    = r_rd_data;
    assign rd_hits    = r_rd_hits;
    assign status     = r_status;
    assign any_status = |r_status;

endmodule

// File: tb/tb_match_regfile.sv
// Directed bench for match_regfile with default parameters.
module tb_match_regfile;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [2:0]  in_key;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [2:0]  cfg_pat;
    logic [2:0]  cfg_mask;
    logic        cfg_en;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic [3:0]  status_clr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [7:0]  rd_hits;
    logic [3:0]  status;
    logic        any_status;

    int n_vec;
    int n_err;

    match_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_key     (in_key),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_pat    (cfg_pat),
        .cfg_mask   (cfg_mask),
        .cfg_en     (cfg_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .status_clr (status_clr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_hits    (rd_hits),
        .status     (status),
        .any_status (any_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        in_valid = 0; cfg_we = 0; wr_en = 0; rd_en = 0; status_clr = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_cfg(input logic [1:0] a, input logic [2:0] p, input logic [2:0] m, input logic e);
        cfg_we = 1; cfg_addr = a; cfg_pat = p; cfg_mask = m; cfg_en = e;
        tick();
    endtask

    task automatic do_key(input logic [2:0] k);
        in_valid = 1; in_key = k;
        tick();
    endtask

    task automatic do_read(input logic [1:0] a);
        rd_en = 1; rd_addr = a;
        tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        idle();
        rst = 1; in_key = 0; cfg_addr = 0; cfg_pat = 0; cfg_mask = 0; cfg_en = 0;
        wr_addr = 0; wr_data = 0; rd_addr = 0;
        tick(); tick();
        rst = 0;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_hits", rd_hits, 0);
        chk("rst_status", status, 0);
        chk("rst_any", any_status, 0);

        // entry 0 exact 001, entry 2 catch-all; preload entry 2 data
        do_cfg(2'd0, 3'b001, 3'b111, 1'b1);
        do_cfg(2'd2, 3'b000, 3'b000, 1'b1);
        wr_en = 1; wr_addr = 2'd2; wr_data = 32'hA5A5A5A5;
        tick();

        do_key(3'b001);
        chk("k001_status", status, 4'b0001);
        chk("k001_any", any_status, 1);
        do_read(2'd0);
        chk("rd0_valid", rd_valid, 1);
        chk("rd0_data", rd_data, 32'hFFFFFFFF);
        chk("rd0_hits", rd_hits, 1);
        do_read(2'd2);
        chk("rd2_data_unchanged", rd_data, 32'hA5A5A5A5);
        chk("rd2_hits0", rd_hits, 0);
        tick();
        chk("idle_rd_valid", rd_valid, 0);
        chk("idle_rd_hold", rd_data, 32'hA5A5A5A5);

        // clear all, then key only the catch-all matches
        status_clr = 4'b1111;
        tick();
        chk("clr_all", status, 0);
        do_key(3'b110);
        chk("k110_status", status, 4'b0100);
        do_read(2'd2);
        chk("k110_hits2", rd_hits, 1);
        chk("k110_data2", rd_data, 32'hFFFFFFFF);

        // host write and match to entry 0 in the same cycle
        wr_en = 1; wr_addr = 2'd0; wr_data = 32'h12345678;
        in_valid = 1; in_key = 3'b001;
        tick();
        chk("wrmatch_status", status, 4'b0101);
        do_read(2'd0);
        chk("wrmatch_data", rd_data, 32'h12345678);
        chk("wrmatch_hits", rd_hits, 1);

        // status clear alone, then clear racing a set
        status_clr = 4'b0001;
        tick();
        chk("clr_alone", status, 4'b0100);
        status_clr = 4'b0001; in_valid = 1; in_key = 3'b001;
        tick();
        chk("clr_vs_set", status, 4'b0101);

        // no-match event: disable the catch-all, clear, key nothing matches
        do_cfg(2'd2, 3'b000, 3'b000, 1'b0);
        status_clr = 4'b1111;
        tick();
        do_key(3'b010);
        chk("nomatch_status", status, 0);
        chk("nomatch_any", any_status, 0);

        // saturation on entry 1
        do_cfg(2'd1, 3'b111, 3'b111, 1'b1);
        in_valid = 1; in_key = 3'b111;
        repeat (300) @(posedge clk);
        #1;
        idle();
        chk("sat_status", status, 4'b0010);
        do_read(2'd1);
        chk("sat_hits", rd_hits, 255);
        do_read(2'd1);
        chk("sat_reread", rd_hits, 0);

        // read racing a match: pre-update count out, counter restarts at 1
        do_key(3'b111);
        do_key(3'b111);
        rd_en = 1; rd_addr = 2'd1; in_valid = 1; in_key = 3'b111;
        tick();
        chk("rdmatch_pre", rd_hits, 2);
        do_read(2'd1);
        chk("rdmatch_post", rd_hits, 1);

        // read racing a write returns old data
        wr_en = 1; wr_addr = 2'd3; wr_data = 32'h0000DEAD; rd_en = 1; rd_addr = 2'd3;
        tick();
        chk("rdwr_pre", rd_data, 0);
        do_read(2'd3);
        chk("rdwr_post", rd_data, 32'h0000DEAD);

        // reset while a read response is pending
        do_key(3'b001);
        rd_en = 1; rd_addr = 2'd0;
        tick();
        rst = 1;
        tick();
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_data", rd_data, 0);
        chk("midrst_hits", rd_hits, 0);
        chk("midrst_status", status, 0);
        rst = 0;
        do_read(2'd0);
        chk("post_rst_data", rd_data, 0);
        do_key(3'b001);
        chk("post_rst_cfg_cleared", status, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/match_regfile.md
MATCH_REGFILE -- requirements
Module: match_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data word width, 8..64.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries, 2..16; AW = clog2(DEPTH).
REQ-003 SHALL have parameter KEYW, default 3: match-key width, 1..16.
REQ-004 SHALL have parameter FILL, default all-ones of WIDTH: word loaded into an entry on a match.
REQ-005 SHALL have ports `clk` (in, 1) as the single clock, sampled on the rising edge.
REQ-006 SHALL have port `rst` (in, 1) as the reset: synchronous and active-high.
REQ-007 SHALL have `in_valid` (in, 1) and `in_key` (in, KEYW): key event strobe.
REQ-008 SHALL have `cfg_we` (in, 1), `cfg_addr` (in, AW), `cfg_pat` (in, KEYW), `cfg_mask` (in, KEYW) and `cfg_en` (in, 1): entry match configuration.
REQ-009 SHALL have `wr_en` (in, 1), `wr_addr` (in, AW) and `wr_data` (in, WIDTH): host data write.
REQ-010 SHALL have `rd_en` (in, 1) and `rd_addr` (in, AW): host read request.
REQ-011 SHALL have `status_clr` (in, DEPTH): write-1-to-clear for the sticky status bits.
REQ-012 SHALL have `rd_valid` (out, 1), `rd_data` (out, WIDTH) and `rd_hits` (out, 8): read response.
REQ-013 SHALL have `status` (out, DEPTH) as the sticky per-entry match flags, and `any_status` (out, 1) as the OR of `status`.

Function
REQ-014 Entry i SHALL match when en[i]=1 and (in_key & mask[i]) == (pat[i] & mask[i]).
REQ-015 On in_valid, only the lowest-index matching entry (the winner) SHALL be updated; higher-index matches SHALL be ignored.
REQ-016 The winner's update SHALL take effect on the next rising edge (latency 1), as follows:
- data[w] <= FILL;
- status[w] <= 1;
- hits[w] <= hits[w]+1, saturating at 255.
REQ-017 An in_valid with no matching entry SHALL change no state.
REQ-018 When cfg_we=1, the module SHALL load pat, mask and en at cfg_addr on the next edge. A key compared in the same cycle SHALL use the old configuration.
REQ-019 A mask value of 0 with en=1 SHALL match every key.
REQ-020 When wr_en=1, the module SHALL write data[wr_addr] <= wr_data. If the same cycle has a match winner at the same address, the host write SHALL win for data only; status and hits SHALL still update.
REQ-021 status_clr[i]=1 SHALL clear status[i] on the next edge. If a set for entry i arrives in the same cycle, the set SHALL win.
REQ-022 A read SHALL return its response one cycle after rd_en: rd_valid=1, rd_data=data[rd_addr], rd_hits=hits[rd_addr].
- A read in the same cycle as a write or match to the same entry SHALL return the pre-update value.
- rd_valid=0 otherwise, with rd_data and rd_hits holding their last value.
REQ-023 Reading an entry SHALL clear its hits counter unless a match to that entry occurs in the same cycle; in that case hits SHALL become 1.
REQ-024 An address at or above DEPTH SHALL be ignored for cfg and wr. A read at such an address SHALL return rd_data=0 and rd_hits=0 with rd_valid=1.
REQ-025 `any_status` SHALL be a registered-path output derived combinationally from `status` only.

Reset
REQ-026 While rst=1 at a rising edge, the module SHALL clear all data, pat, mask, en, hits and status, and drive rd_valid=0, rd_data=0, rd_hits=0. All other inputs SHALL be ignored that cycle.
REQ-027 rst asserted mid-operation SHALL discard any in-flight read response. The first usable cycle SHALL be the one after rst deasserts.

Structure
REQ-028 The clog2 function, the hit-counter width constant (8) and its saturation value (255) SHALL live in the shared package match_regfile_pkg.
REQ-029 The lowest-index winner selection SHALL be a sub-module named match_prio_enc, with a DEPTH-bit request input, a one-hot grant output and a found flag.
REQ-030 The storage SHALL be flops, not inferred RAM, so that it resets per REQ-026.

Verification
REQ-031 The bench SHALL run each directed scenario below with default parameters and check the stated response.
- Config: entry 0 pat=3'b001, mask=3'b111, en=1; entry 2 mask=0, en=1. Stimulus: in_key=3'b001 -> next cycle data[0]=32'hFFFFFFFF, status=4'b0001, data[2] unchanged.
- Same config. Stimulus: in_key=3'b110 -> status=4'b0100, hits[2]=1.
- Same cycle: wr_en to addr 0 with 32'h12345678, plus a key matching entry 0 -> data[0]=32'h12345678, status[0]=1, hits[0]=1.
- Status race: status set -> clear with status_clr=4'b0001 alone gives status[0]=0; clear together with a new match gives status[0]=1.
- Saturation: 300 matches to entry 1 -> rd_hits=255; a second read returns rd_hits=0.
- Reset mid-operation: rst=1 in the cycle after rd_en -> rd_valid=0, all outputs 0, status=0.
